dsp_op_sequencer: RTL
=====================

Name: dsp_op_sequencer

Overview:
Initiator-side controller for the team's DSP48A1-style slice. It accepts operand transactions on a valid/ready stream and drives the slice's A/B/C/D/OPMODE/CARRYIN, CE and reset inputs. It tracks every operation through the slice pipeline with a valid tag and collects P/CARRYOUT into a result FIFO that is returned on a valid/ready stream. Credit-based issue guarantees no result is lost under output backpressure. It sits between a packet or datapath front-end and one DSP slice.

Parameters:
LATENCY, 4, cycles from the slice sampling its inputs to P/CARRYOUT being valid (slice pipeline depth)
FIFO_DEPTH, 8, result FIFO entries; also the maximum number of operations outstanding (in flight plus buffered)
RST_CYCLES, 2, cycles DSP_RST is held high in INIT

Ports:
CLK  in  1  clock; all logic is on the rising edge
RST  in  1  synchronous, active-high reset
FLUSH  in  1  level request to drain and re-initialise the slice
S_VALID  in  1  operand transaction valid
S_READY  out  1  operand transaction accepted when high together with S_VALID
S_A / S_B / S_D  in  18 each  operands
S_C  in  48  operand
S_OPMODE  in  8  slice opcode, forwarded unchanged
S_CARRYIN  in  1  carry in
DSP_A / DSP_B / DSP_D  out  18 each  slice operands
DSP_C  out  48  slice operand
DSP_OPMODE  out  8  slice opcode
DSP_CARRYIN  out  1  slice carry in
DSP_CE  out  1  drives all slice clock enables
DSP_RST  out  1  drives all slice RST* inputs
DSP_P  in  48  slice result
DSP_CARRYOUT  in  1  slice carry out
M_VALID  out  1  result available
M_READY  in  1  result consumer ready
M_P  out  48  result
M_CARRYOUT  out  1  result carry out
BUSY  out  1  high when state != RUN or occupancy != 0

Behaviour:
- Reset (RST=1 at an edge):
  - state goes to INIT and the INIT counter clears.
  - DSP_RST=1, DSP_CE=0, S_READY=0, M_VALID=0, BUSY=1.
  - All DSP_* data outputs are set to 0.
  - The valid tag shift register and FIFO clear, which discards all in-flight and buffered results.
  - RST overrides FLUSH and every handshake in the same cycle.
- FSM:
  - INIT: DSP_RST=1, DSP_CE=0, S_READY=0 for exactly RST_CYCLES cycles, then RUN.
  - RUN: DSP_RST=0, DSP_CE=1. FLUSH=1 moves the FSM to DRAIN.
  - DRAIN: S_READY=0, DSP_CE=1. When in_flight==0 and the FIFO is empty, go to INIT. FLUSH is ignored outside RUN.
- Issue:
  - S_READY = (state==RUN) && !FLUSH && (in_flight + fifo_count < FIFO_DEPTH).
  - S_READY is computed only from registered counts; a same-cycle FIFO pop does not free a credit.
  - On a handshake at edge t, the S_* fields load into the DSP_* output registers and tag[0]=1.
  - With no handshake, the DSP_* registers hold their values and tag[0]=0.
- Pipeline tracking:
  - The tag shift register is LATENCY+1 stages deep and advances every cycle while DSP_CE=1. The slice free-runs and bubbles are invalid tags.
  - The result of the operation issued at edge t is pushed (DSP_P, DSP_CARRYOUT) into the FIFO at edge t+LATENCY+1, when tag[LATENCY]=1.
  - in_flight = popcount of tags. It increments on issue and decrements on push.
- Throughput and ordering: one operation per cycle sustained while M_READY=1. Results return in issue order.
- Output FIFO:
  - First-word-fall-through: M_VALID = !empty, and M_P/M_CARRYOUT show the head entry.
  - A pop occurs on M_VALID && M_READY.
  - Simultaneous push and pop leaves the count unchanged.
  - Overflow is impossible by construction; an assertion fires if a push occurs while full.
  - Pointers wrap modulo FIFO_DEPTH.
  - M_P and M_CARRYOUT stay stable while M_VALID=1 and M_READY=0.
- Arithmetic: none internally; values pass through unmodified.

Test Plan:
- Reset: RST high 1 cycle, then low -> DSP_RST=1 and S_READY=0 for exactly 2 cycles; S_READY=1 on the 3rd cycle; M_VALID=0 throughout.
- Single op: the bench uses a behavioural slice stub with P = A*B + C and a 4-cycle latency. Issue A=3, B=5, C=7, D=0, OPMODE=8'h0D at edge t -> M_VALID rises after edge t+5 with M_P=22, M_CARRYOUT=0.
- Streaming: 16 back-to-back ops with A=i, B=2, C=0 and M_READY=1 -> S_READY never drops; M_P = 0, 2, 4 … 30 on consecutive cycles in order.
- Backpressure: M_READY=0, offer 12 ops -> exactly 8 accepted and S_READY stays 0. Raise M_READY -> 8 results in order, then S_READY returns; no result is lost or duplicated.
- Flush: 3 ops in flight, pulse FLUSH -> S_READY=0 and all 3 results delivered. The FSM then passes through INIT with DSP_RST high for 2 cycles, then back to RUN; BUSY=1 throughout.
- Mid-op reset: 5 ops outstanding, M_READY=0, assert RST -> M_VALID=0 after the edge. FIFO empty and no stale result emerges later; INIT sequence repeats.

Source files
------------

// File: rtl/dsp_op_sequencer.sv
// dsp_op_sequencer: issue/collect controller for one DSP48A1-style slice.
// Tracks ops through the slice with a valid tag and buffers results in a FWFT FIFO.
module dsp_op_sequencer #(
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int RST_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        FLUSH,
   input  logic        S_VALID,
   output logic        S_READY,
   input  logic [17:0] S_A,
   input  logic [17:0] S_B,
   input  logic [17:0] S_D,
   input  logic [47:0] S_C,
   input  logic [7:0]  S_OPMODE,
   input  logic        S_CARRYIN,
   output logic [17:0] DSP_A,
   output logic [17:0] DSP_B,
   output logic [17:0] DSP_D,
   output logic [47:0] DSP_C,
   output logic [7:0]  DSP_OPMODE,
   output logic        DSP_CARRYIN,
   output logic        DSP_CE,
   output logic        DSP_RST,
   input  logic [47:0] DSP_P,
   input  logic        DSP_CARRYOUT,
   output logic        M_VALID,
   input  logic        M_READY,
   output logic [47:0] M_P,
   output logic        M_CARRYOUT,
   output logic        BUSY
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(FIFO_DEPTH + LATENCY + 2);
   localparam int IW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   init_cnt_q, init_cnt_d;

   logic [LATENCY:0] tag_q, tag_d;
   logic [48:0]     mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [17:0]     a_q, b_q, d_q;
   logic [47:0]     c_q;
   logic [7:0]      op_q;
   logic            ci_q;

   logic [OW-1:0]   in_flight;
   logic [OW-1:0]   occ;
   logic            run;
   logic            issue;
   logic            push;
   logic            pop;

   // Outstanding ops = valid tags in the slice plus buffered results
   always_comb begin
      in_flight = '0;
      for (int i = 0; i <= LATENCY; i++) begin
         if (tag_q[i]) in_flight = in_flight + OW'(1);
      end
      occ = in_flight + OW'(cnt_q);
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // FSM next state: hold slice reset, run, then drain everything on flush
   always_comb begin
      state_d    = state_q;
      init_cnt_d = '0;
      unique case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q + IW'(1);
            if (init_cnt_q == IW'(RST_CYCLES - 1)) begin
               state_d    = ST_RUN;
               init_cnt_d = '0;
            end
         end
         ST_RUN: begin
            if (FLUSH) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (occ == '0) state_d = ST_INIT;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // FSM outputs; credits come only from registered counts
   always_comb begin
      run     = (state_q == ST_RUN);
      DSP_RST = (state_q == ST_INIT);
      DSP_CE  = (state_q != ST_INIT);
      S_READY = run && !FLUSH && (occ < OW'(FIFO_DEPTH));
      BUSY    = !run || (occ != '0);
   end

   assign issue   = S_VALID && S_READY;
   assign push    = tag_q[LATENCY];
   assign M_VALID = (cnt_q != '0);
   assign pop     = M_VALID && M_READY;

   // Tag shift and FIFO pointer/count next state
   always_comb begin
      tag_d  = tag_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (DSP_CE) tag_d = {tag_q[LATENCY-1:0], issue};
      if (push) begin
         wptr_d = (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end
      if (push && !pop) cnt_d = cnt_q + CW'(1);
      if (!push && pop) cnt_d = cnt_q - CW'(1);
   end

   // Operand registers, tags and FIFO control
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_q    <= '0;
         b_q    <= '0;
         d_q    <= '0;
         c_q    <= '0;
         op_q   <= '0;
         ci_q   <= 1'b0;
         tag_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (issue) begin
            a_q  <= S_A;
            b_q  <= S_B;
            d_q  <= S_D;
            c_q  <= S_C;
            op_q <= S_OPMODE;
            ci_q <= S_CARRYIN;
         end
         tag_q  <= tag_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Result storage; credits make a push into a full FIFO unreachable
   always_ff @(posedge CLK) begin
      if (push) mem_q[wptr_q] <= {DSP_CARRYOUT, DSP_P};
      if (!RST && push) assert (cnt_q != CW'(FIFO_DEPTH) || pop);
   end

   assign DSP_A       = a_q;
   assign DSP_B       = b_q;
   assign DSP_D       = d_q;
   assign DSP_C       = c_q;
   assign DSP_OPMODE  = op_q;
   assign DSP_CARRYIN = ci_q;
   assign {M_CARRYOUT, M_P} = mem_q[rptr_q];

endmodule
